uart_tx_ctrl: RTL

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO feeding an 8N1 serializer with a latched baud divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
`timescale 1ns/1ps
module uart_tx_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_en,
   input  logic [DIV_W-1:0]              bauddiv,
   input  logic                          wr_valid,
   input  logic [7:0]                    wr_data,
   output logic                          wr_ready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          tx_done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t           state;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [7:0]       shreg;
   logic [DIV_W-1:0] div_lat, baud_cnt, cnt_nxt;
   logic [2:0]       bit_idx;
   logic             bit_end, push, pop;
`ifdef UART_TX_PARITY_EN
   logic             par;
`endif

   // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
   assign wr_ready = (fifo_cnt < CW'(FIFO_DEPTH));
   assign push     = wr_valid && wr_ready;
   assign bit_end  = (baud_cnt == div_lat);
   assign cnt_nxt  = baud_cnt + DIV_W'(1);
   assign pop      = tx_en && (fifo_cnt != '0) &&
                     ((state == IDLE) || ((state == STOP) && bit_end));

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         txd      <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
         shreg    <= '0;
         div_lat  <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         if (pop) begin
            // Covers both the idle start and the back-to-back restart at stop end.
            state    <= START;
            txd      <= 1'b0;
            busy     <= 1'b1;
            shreg    <= mem[rptr];
            div_lat  <= bauddiv;
            baud_cnt <= '0;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= ^mem[rptr];
`endif
         end else begin
            case (state)
               IDLE: begin
                  txd  <= 1'b1;
                  busy <= 1'b0;
               end
               START: begin
                  if (bit_end) begin
                     state    <= DATA;
                     txd      <= shreg[0];
                     shreg    <= shreg >> 1;
                     baud_cnt <= '0;
                  end else baud_cnt <= cnt_nxt;
               end
               DATA: begin
                  if (bit_end) begin
                     baud_cnt <= '0;
                     if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state   <= PARITY;
                        txd     <= par;
`else
                        state   <= STOP;
                        txd     <= 1'b1;
                        tx_done <= (div_lat == '0);
`endif
                     end else begin
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end else baud_cnt <= cnt_nxt;
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  if (bit_end) begin
                     state    <= STOP;
                     txd      <= 1'b1;
                     baud_cnt <= '0;
                     tx_done  <= (div_lat == '0);
                  end else baud_cnt <= cnt_nxt;
               end
`endif
               STOP: begin
                  if (bit_end) begin
                     state <= IDLE;
                     txd   <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     baud_cnt <= cnt_nxt;
                     tx_done  <= (cnt_nxt == div_lat);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
